// File: rtl/mod_cnt_pkg.sv
// Shared constants and helpers for the cascaded modulo-N counter.
package mod_cnt_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Out-of-range digit values collapse onto the largest legal value.
    function automatic int unsigned digit_clamp(input int unsigned v, input int unsigned mod);
        return (v >= mod) ? mod - 1 : v;
    endfunction

endpackage

// File: rtl/mod_cnt_digit.sv
// One modulo-MOD digit: sync reset, clamped load, up/down step when enabled by the ripple chain.
module mod_cnt_digit
    import mod_cnt_pkg::*;
#(
    parameter  int unsigned MOD = 12,
    localparam int unsigned W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_in,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] ld_digit,
    output logic [W-1:0] q_digit,
    output logic         at_term
);

    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = W'(digit_clamp(32'(ld_digit), MOD));
        end else if (en_in) begin
            if (up_dn == DIR_UP) begin
                q_d = (q_q == MAXV) ? '0 : q_q + W'(1);
            end else begin
                q_d = (q_q == '0) ? MAXV : q_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_digit = q_q;
    assign at_term = (up_dn == DIR_DN) ? (q_q == '0) : (q_q == MAXV);

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Cascaded modulo-MOD counter of DIGITS digits with tc, carry and sat outputs.
// Define MODCNT_SAT_EN to make the chain saturate at its terminal state instead of wrapping.
module mod_n_cascade_counter
    import mod_cnt_pkg::*;
#(
    parameter  int unsigned MOD    = 12,
    parameter  int unsigned DIGITS = 2,
    localparam int unsigned W      = $clog2(MOD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_val,
    output logic [DIGITS*W-1:0] q,
    output logic                tc,
    output logic                carry,
    output logic                sat
);

    logic [DIGITS-1:0] at_term;
    logic [DIGITS-1:0] en_chain;
    logic              all_term;
    logic              en_eff;
    logic              carry_q, carry_d;

    assign all_term = &at_term;
    assign tc       = en & all_term;

`ifdef MODCNT_SAT_EN
    assign en_eff = en & ~all_term;
`else
    assign en_eff = en;
`endif

    // Digit k steps only when every lower digit is about to wrap.
    always_comb begin : p_ripple
        logic run;
        run = en_eff;
        for (int k = 0; k < DIGITS; k++) begin
            en_chain[k] = run;
            run         = run & at_term[k];
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        mod_cnt_digit #(.MOD(MOD)) u_digit (
            .clk      (clk),
            .rst      (rst),
            .en_in    (en_chain[k]),
            .up_dn    (up_dn),
            .load     (load),
            .ld_digit (load_val[k*W +: W]),
            .q_digit  (q[k*W +: W]),
            .at_term  (at_term[k])
        );
    end

    always_comb begin
        carry_d = 1'b0;
`ifndef MODCNT_SAT_EN
        if (!load) begin
            carry_d = tc;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;

`ifdef MODCNT_SAT_EN
    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    logic [W-1:0] term_val;
    logic         upper_term;
    logic         near_lsd;
    logic         ld_term;
    logic         sat_q, sat_d;

    assign term_val = (up_dn == DIR_UP) ? MAXV : '0;

    // A step lands on the terminal state only when the LSD is one step short
    // and every higher digit already sits at terminal.
    always_comb begin : p_upper
        upper_term = 1'b1;
        for (int k = 1; k < DIGITS; k++) begin
            upper_term = upper_term & at_term[k];
        end
    end

    assign near_lsd = (q[W-1:0] == ((up_dn == DIR_UP) ? W'(MOD - 2) : W'(1)));

    always_comb begin : p_ld_term
        ld_term = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (W'(digit_clamp(32'(load_val[k*W +: W]), MOD)) != term_val) begin
                ld_term = 1'b0;
            end
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (load) begin
            sat_d = ld_term;
        end else if (en_eff) begin
            sat_d = upper_term & near_lsd;
        end else begin
            sat_d = all_term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Directed table-driven bench for mod_n_cascade_counter (MOD=12, DIGITS=2), plus wrap/saturation sequences.
module tb_mod_n_cascade_counter;

  localparam int MOD    = 12;
  localparam int DIGITS = 2;
  localparam int NV     = 17;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       tc, carry, sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_n_cascade_counter #(.MOD(MOD), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .carry    (carry),
    .sat      (sat)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic       up_dn;
    logic [7:0] lv;
    logic       exp_tc;
    logic [7:0] exp_q;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic ld, input logic e, input logic u,
                              input logic [7:0] lv, input logic etc, input logic [7:0] eq,
                              input logic ec);
    vec_t v;
    v.rst = r; v.load = ld; v.en = e; v.up_dn = u; v.lv = lv;
    v.exp_tc = etc; v.exp_q = eq; v.exp_carry = ec;
    return v;
  endfunction

  function automatic logic [7:0] enc(input int n);
    return {4'(n / MOD), 4'(n % MOD)};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic e, input logic u,
                       input logic [7:0] lv);
    rst = r; load = ld; en = e; up_dn = u; load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Non-terminal table: identical expectations with and without saturation.
    vecs[0]  = mk(0, 1, 1, 1, 8'h0B, 0, 8'h0B, 0);
    vecs[1]  = mk(0, 0, 1, 1, 8'h00, 0, 8'h10, 0);
    vecs[2]  = mk(0, 1, 0, 0, 8'hFF, 0, 8'hBB, 0);
    vecs[3]  = mk(0, 0, 1, 0, 8'h00, 0, 8'hBA, 0);
    vecs[4]  = mk(0, 1, 1, 1, 8'hC5, 0, 8'hB5, 0);
    vecs[5]  = mk(1, 1, 1, 1, 8'h37, 0, 8'h00, 0);
    vecs[6]  = mk(0, 1, 0, 1, 8'h37, 0, 8'h37, 0);
    vecs[7]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h37, 0);
    vecs[8]  = mk(0, 0, 0, 1, 8'h00, 0, 8'h37, 0);
    vecs[9]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h37, 0);
    vecs[10] = mk(0, 0, 0, 1, 8'h00, 0, 8'h37, 0);
    vecs[11] = mk(0, 0, 0, 0, 8'h00, 0, 8'h37, 0);
    vecs[12] = mk(0, 0, 1, 0, 8'h00, 0, 8'h36, 0);
    vecs[13] = mk(0, 1, 0, 1, 8'h0C, 0, 8'h0B, 0);
    vecs[14] = mk(0, 0, 1, 0, 8'h00, 0, 8'h0A, 0);
    vecs[15] = mk(0, 1, 0, 1, 8'h10, 0, 8'h10, 0);
    vecs[16] = mk(0, 0, 1, 0, 8'h00, 0, 8'h0B, 0);

    // Reset from an arbitrary loaded value, held for two edges.
    drive(0, 1, 0, 1, 8'h5A);
    tick();
    chk("preload_q", q, 8'h5A);
    drive(1, 0, 1, 1, 8'h00);
    tick();
    chk("rst1_q", q, 8'h00);
    tick();
    chk("rst2_q", q, 8'h00);
    chk("rst2_carry", 8'(carry), 8'h00);
    chk("rst2_sat", 8'(sat), 8'h00);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up_dn, vecs[i].lv);
      #1;
      chk($sformatf("v%0d_tc", i), 8'(tc), 8'(vecs[i].exp_tc));
      tick();
      chk($sformatf("v%0d_q", i), q, vecs[i].exp_q);
      chk($sformatf("v%0d_carry", i), 8'(carry), 8'(vecs[i].exp_carry));
      chk($sformatf("v%0d_sat", i), 8'(sat), 8'h00);
    end

`ifndef MODCNT_SAT_EN
    // Full up sweep 0..143 with wrap on the last edge.
    drive(1, 0, 0, 1, 8'h00);
    tick();
    chk("sweep_start_q", q, 8'h00);
    for (int n = 0; n < MOD * MOD; n++) begin
      drive(0, 0, 1, 1, 8'h00);
      #1;
      chk($sformatf("up%0d_tc", n), 8'(tc), 8'(n == MOD * MOD - 1));
      tick();
      chk($sformatf("up%0d_q", n), q, enc((n + 1) % (MOD * MOD)));
      chk($sformatf("up%0d_carry", n), 8'(carry), 8'(n == MOD * MOD - 1));
    end
    drive(0, 0, 0, 1, 8'h00);
    tick();
    chk("post_wrap_carry", 8'(carry), 8'h00);
    chk("post_wrap_q", q, 8'h00);

    // Down wrap from zero, then a plain decrement.
    drive(0, 0, 1, 0, 8'h00);
    #1;
    chk("dn_wrap_tc", 8'(tc), 8'h01);
    tick();
    chk("dn_wrap_q", q, 8'hBB);
    chk("dn_wrap_carry", 8'(carry), 8'h01);
    tick();
    chk("dn_next_q", q, 8'hBA);
    chk("dn_next_carry", 8'(carry), 8'h00);
`else
    // Saturation: hold at the up terminal, then leave it by stepping down.
    drive(0, 1, 0, 1, 8'hBA);
    tick();
    chk("sat_load_q", q, 8'hBA);
    chk("sat_load_sat", 8'(sat), 8'h00);
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 1, 1, 8'h00);
      tick();
      chk($sformatf("sat_up%0d_q", n), q, 8'hBB);
      chk($sformatf("sat_up%0d_carry", n), 8'(carry), 8'h00);
      chk($sformatf("sat_up%0d_sat", n), 8'(sat), 8'h01);
    end
    drive(0, 0, 1, 0, 8'h00);
    tick();
    chk("sat_dn_q", q, 8'hBA);
    chk("sat_dn_sat", 8'(sat), 8'h00);
    chk("sat_dn_carry", 8'(carry), 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
